residual_add_seq: RTL
=====================

// Module: residual_add_seq
// PURPOSE
//   Responder side of the start/done stage handshake used by the ViT encoder FSM.
//   Computes the residual y = x + sub element-wise over a (SEQ_LEN x EMB_DIM) tile,
//   LANES elements per cycle, with signed saturation.
//   Drop-in stage for both residual slots of the encoder block (attn and MLP).
// PARAMETERS
//   DATA_WIDTH  16  element width, signed two's complement fixed point
//   SEQ_LEN     8   tokens per tile
//   EMB_DIM     8   embedding dim; NELEM = SEQ_LEN*EMB_DIM
//   LANES       4   adders per cycle; NELEM % LANES must be 0 (elab $error otherwise)
// PORTS
//   clk        in   1                      clock, all logic on rising edge
//   rst        in   1                      synchronous reset, active-high
//   start      in   1                      job request; sampled only in S_IDLE
//   x_in       in   DATA_WIDTH*NELEM       skip-path operand, element i at [i*DW +: DW]
//   sub_in     in   DATA_WIDTH*NELEM       sublayer operand, same layout
//   done       out  1                      1-cycle pulse, job complete
//   out_valid  out  1                      high with done; y_out final for this job
//   busy       out  1                      high in S_RUN and S_DONE
//   sat_flag   out  1                      >=1 element saturated in last job; held until next start
//   y_out      out  DATA_WIDTH*NELEM       result register
// BEHAVIOUR
//   Reset (rst=1 at edge, any state): state=S_IDLE, chunk counter=0, done=0,
//     out_valid=0, busy=0, sat_flag=0, y_out=0, operand snapshots=0.
//     rst overrides start in the same cycle.
//   NCHUNK = NELEM/LANES; counter width $clog2(NCHUNK)+1.
//   FSM states:
//     S_IDLE: start=1 -> latch x_in, sub_in into snapshot regs; cnt=0; sat_flag=0;
//       go to S_RUN. start=0 -> stay.
//     S_RUN: add chunk cnt (elements cnt*LANES .. cnt*LANES+LANES-1) from the
//       snapshots; write them to y_out; OR the per-lane overflow into sat_flag.
//       cnt==NCHUNK-1 -> S_DONE; else cnt++.
//     S_DONE: done=1, out_valid=1 (Moore outputs, exactly one cycle) -> S_IDLE.
//   Latency: start sampled at edge E0; done high in cycle E0+NCHUNK+1.
//     Next start is accepted in the cycle after done.
//   Start handling: start while busy is ignored, not queued.
//     Input changes after E0 do not affect the job (snapshot).
//   Arithmetic: sum = sext(x)+sext(sub) at DATA_WIDTH+1 bits.
//     If sum > 2^(DW-1)-1: output 0x7FFF (for DW=16), sat lane.
//     If sum < -2^(DW-1): output 0x8000, sat lane.
//     Otherwise output sum[DW-1:0].
//     Fixed-point scale is unchanged (both operands share a Q format).
//   y_out: chunks not yet written in a job hold the previous job's values.
//     All bits are final only when out_valid=1.
//     Holds until the first S_RUN write of the next job.
//   Mid-job rst: job is abandoned, all outputs cleared, no done pulse.
// TESTING  (SEQ_LEN=2, EMB_DIM=4, LANES=4 -> NCHUNK=2)
//   1 Basic: x[i]=i, sub[i]=10*i, start 1 cycle -> done/out_valid high exactly
//     3 cycles after the start edge; y[i]=11*i; sat_flag=0; done low next cycle.
//   2 Saturation: x[0]=0x7FF0, sub[0]=0x0100; x[5]=0x8000, sub[5]=0xFFFF
//     -> y[0]=0x7FFF, y[5]=0x8000, sat_flag=1; others exact.
//   3 Snapshot: start with x=1,sub=1, then change x_in to 0x0100 next cycle
//     -> all y=0x0002.
//   4 Busy ignore: start held high 5 cycles -> one done pulse at cycle 3, then
//     a second job accepted at cycle 4; no start dropped after IDLE return.
//   5 Reset mid-job: assert rst in the cycle after the start edge -> next cycle
//     y_out=0, busy=0, no done.
//     A fresh start then completes normally in 3 cycles.
//   6 Handshake with encoder FSM: instantiate in both residual slots with stub
//     stages -> encoder reaches its done state; out_block = x+attn+mlp.

Source files
------------

// File: rtl/residual_add_seq.sv
// residual_add_seq
//   Start/done responder stage computing y = x + sub over a SEQ_LEN x EMB_DIM
//   tile, LANES saturating adders per cycle. Operands are snapshotted when a
//   job is accepted, so the caller may change its inputs while the job runs.
//   The same block serves both residual slots of the encoder (attn and MLP).

module residual_add_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int SEQ_LEN    = 8,
  parameter int EMB_DIM    = 8,
  parameter int LANES      = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [DATA_WIDTH*SEQ_LEN*EMB_DIM-1:0] x_in,
  input  logic [DATA_WIDTH*SEQ_LEN*EMB_DIM-1:0] sub_in,
  output logic                                  done,
  output logic                                  out_valid,
  output logic                                  busy,
  output logic                                  sat_flag,
  output logic [DATA_WIDTH*SEQ_LEN*EMB_DIM-1:0] y_out
);

  localparam int NELEM  = SEQ_LEN * EMB_DIM;
  localparam int NCHUNK = NELEM / LANES;
  localparam int CW     = $clog2(NCHUNK) + 1;
  localparam int TW     = DATA_WIDTH * NELEM;
  localparam int CHW    = DATA_WIDTH * LANES;

  // The tile must split into whole chunks; anything else is a configuration error.
  if ((NELEM % LANES) != 0) begin : g_lane_check
    $error("residual_add_seq: NELEM must be a multiple of LANES");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Saturating signed add. Returns {saturated, result}. The sum is formed one
  // bit wider than the operands; overflow shows up as the top two bits of the
  // wide sum disagreeing, and the top bit then tells the overflow direction.
  function automatic logic [DATA_WIDTH:0] sat_add(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH-1:0] res;
    logic                  sat;
    sum = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]) begin
      sat = 1'b1;
      if (sum[DATA_WIDTH]) begin
        res = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      end else begin
        res = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end
    end else begin
      sat = 1'b0;
      res = sum[DATA_WIDTH-1:0];
    end
    return {sat, res};
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   x_snap_q, x_snap_d;
  logic [TW-1:0]   sub_snap_q, sub_snap_d;
  logic [TW-1:0]   y_q, y_d;
  logic            sat_q, sat_d;
  logic            done_q, done_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;

  logic [31:0]      chunk_base_s;
  logic [CHW-1:0]   x_chunk_s;
  logic [CHW-1:0]   sub_chunk_s;
  logic [CHW-1:0]   y_chunk_s;
  logic [LANES-1:0] lane_sat_s;

  // Select the active chunk from the snapshots and run the LANES adders on it.
  always_comb begin
    chunk_base_s = 32'(cnt_q) * 32'(CHW);
    x_chunk_s    = x_snap_q[chunk_base_s +: CHW];
    sub_chunk_s  = sub_snap_q[chunk_base_s +: CHW];
    y_chunk_s    = {CHW{1'b0}};
    lane_sat_s   = {LANES{1'b0}};
    for (int l = 0; l < LANES; l++) begin
      {lane_sat_s[l], y_chunk_s[l*DATA_WIDTH +: DATA_WIDTH]} =
        sat_add(x_chunk_s[l*DATA_WIDTH +: DATA_WIDTH],
                sub_chunk_s[l*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  // Next-state logic; done/out_valid/busy are computed for the state being
  // entered so that the registered copies line up with the FSM state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_snap_d    = x_snap_q;
    sub_snap_d  = sub_snap_q;
    y_d         = y_q;
    sat_d       = sat_q;
    done_d      = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RUN;
          x_snap_d   = x_in;
          sub_snap_d = sub_in;
          cnt_d      = {CW{1'b0}};
          sat_d      = 1'b0;
          busy_d     = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        y_d[chunk_base_s +: CHW] = y_chunk_s;
        sat_d                    = sat_q | (|lane_sat_s);
        busy_d                   = 1'b1;
        if (cnt_q == CW'(NCHUNK - 1)) begin
          state_d     = S_DONE;
          done_d      = 1'b1;
          out_valid_d = 1'b1;
        end else begin
          state_d = S_RUN;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        // A start seen here is dropped: the stage only listens in S_IDLE.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // State and datapath registers with synchronous reset; reset also abandons a running job.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= {CW{1'b0}};
      x_snap_q    <= {TW{1'b0}};
      sub_snap_q  <= {TW{1'b0}};
      y_q         <= {TW{1'b0}};
      sat_q       <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_snap_q    <= x_snap_d;
      sub_snap_q  <= sub_snap_d;
      y_q         <= y_d;
      sat_q       <= sat_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sat_flag  = sat_q;
  assign y_out     = y_q;

endmodule
